rf_write_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters.
- Requester 1 is the in-order pipeline write-back result: rd plus the selected result (ALU result or load data) after the write-back mux. It has fixed priority.
- Requester 2 is an out-of-pipeline long-latency unit (divider/CSR-side unit) using a valid/ready handshake.
- A starvation counter forces a one-cycle pipeline stall so the long-latency unit is guaranteed a write slot. The block sits between write-back and the register file.

---
 rtl/rf_write_arbiter.sv | 98 +++++++++
 tb/tb_rf_write_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back has fixed priority and a long-latency unit uses valid/ready.
// Write path has one-cycle latency; a starved ext request forces a one-cycle pipeline stall to get its slot.
module rf_write_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ext_valid,
  input  logic [4:0]      ext_rd,
  input  logic [XLEN-1:0] ext_data,
  output logic            ext_ready,
  output logic            stall_req,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd
);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              grant_wb, grant_ext, grant;
  logic [4:0]        sel_rd;
  logic [XLEN-1:0]   sel_data;

  always_comb begin
    grant_wb  = 1'b0;
    grant_ext = 1'b0;
    if (state == FORCE) begin
      grant_ext = ext_valid;
    end else begin
      grant_wb  = wb_valid;
      grant_ext = ext_valid && !wb_valid;
    end
  end

  assign grant     = grant_wb || grant_ext;
  assign ext_ready = grant_ext && !reset;
  assign sel_rd    = grant_ext ? ext_rd   : wb_rd;
  assign sel_data  = grant_ext ? ext_data : wb_data;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (ext_valid && wb_valid) begin
          state_nx = WAIT;
          cnt_nx   = CNT_W'(1);
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      WAIT: begin
        if (grant_ext) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(STARVE_LIMIT)) begin
          state_nx = FORCE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        // FORCE always lasts one cycle, even if the ext unit broke protocol and dropped valid.
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      stall_req <= 1'b0;
      rf_we     <= 1'b0;
      rf_rd     <= '0;
      rf_wd     <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      stall_req <= (state_nx == FORCE);
      rf_we     <= grant && (sel_rd != 5'd0);
      if (grant) begin
        rf_rd <= sel_rd;
        rf_wd <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, a reset-mid-WAIT sequence, and random traffic vs a blocked-cycle model.
module tb_rf_write_arbiter;
  localparam int XLEN  = 32;
  localparam int LIMIT = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ext_valid;
  logic [4:0]      ext_rd;
  logic [XLEN-1:0] ext_data;
  logic            ext_ready;
  logic            stall_req;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;

  rf_write_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ext_valid(ext_valid), .ext_rd(ext_rd), .ext_data(ext_data),
    .ext_ready(ext_ready), .stall_req(stall_req),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        exv;
    logic [4:0]  exrd;
    logic [31:0] exd;
    logic        e_ready;
    logic        e_stall;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Inputs change at the falling edge; every output is sampled 1 time unit later.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst; wb_valid = v.wbv; wb_rd = v.wbrd; wb_data = v.wbd;
    ext_valid = v.exv; ext_rd = v.exrd; ext_data = v.exd;
    #1;
    chk({tag, ".ext_ready"}, 32'(ext_ready), 32'(v.e_ready));
    chk({tag, ".stall_req"}, 32'(stall_req), 32'(v.e_stall));
    chk({tag, ".rf_we"},     32'(rf_we),     32'(v.e_we));
    chk({tag, ".rf_rd"},     32'(rf_rd),     32'(v.e_rd));
    chk({tag, ".rf_wd"},     rf_wd,          v.e_wd);
  endtask

  vec_t vecs[17];
  vec_t v;

  // Reference model: consecutive blocked cycles of the pending ext request plus the last write.
  int          m_blk;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic        ex_pend;
  logic [4:0]  p_rd;
  logic [31:0] p_d;

  initial begin
    reset = 1'b1; wb_valid = 0; wb_rd = 0; wb_data = 0;
    ext_valid = 0; ext_rd = 0; ext_data = 0;
    repeat (2) @(negedge clk);

    //           rst wbv wbrd  wbd           exv exrd  exd           rdy stl we  rd     wd
    vecs[0]  = '{1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0,  0,  0,  5'd0,  32'h0};
    vecs[1]  = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0,  0,  0,  5'd0,  32'h0};
    vecs[2]  = '{0, 1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        0,  0,  0,  5'd0,  32'h0};
    vecs[3]  = '{0, 1, 5'd0,  32'h11111111, 0, 5'd0,  32'h0,        0,  0,  1,  5'd5,  32'hDEADBEEF};
    vecs[4]  = '{0, 0, 5'd0,  32'h0,        1, 5'd10, 32'h12345678, 1,  0,  0,  5'd0,  32'h11111111};
    vecs[5]  = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0,  0,  1,  5'd10, 32'h12345678};
    vecs[6]  = '{0, 1, 5'd3,  32'hA3,       1, 5'd4,  32'hB4,       0,  0,  0,  5'd10, 32'h12345678};
    vecs[7]  = '{0, 0, 5'd0,  32'h0,        1, 5'd4,  32'hB4,       1,  0,  1,  5'd3,  32'hA3};
    vecs[8]  = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0,  0,  1,  5'd4,  32'hB4};
    vecs[9]  = '{0, 1, 5'd7,  32'h77,       1, 5'd9,  32'h99,       0,  0,  0,  5'd4,  32'hB4};
    vecs[10] = '{0, 1, 5'd7,  32'h77,       1, 5'd9,  32'h99,       0,  0,  1,  5'd7,  32'h77};
    vecs[11] = '{0, 1, 5'd7,  32'h77,       1, 5'd9,  32'h99,       0,  0,  1,  5'd7,  32'h77};
    vecs[12] = '{0, 1, 5'd7,  32'h77,       1, 5'd9,  32'h99,       0,  0,  1,  5'd7,  32'h77};
    vecs[13] = '{0, 1, 5'd7,  32'h77,       1, 5'd9,  32'h99,       0,  0,  1,  5'd7,  32'h77};
    vecs[14] = '{0, 1, 5'd7,  32'h77,       1, 5'd9,  32'h99,       1,  1,  1,  5'd7,  32'h77};
    vecs[15] = '{0, 1, 5'd7,  32'h77,       0, 5'd0,  32'h0,        0,  0,  1,  5'd9,  32'h99};
    vecs[16] = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0,  0,  1,  5'd7,  32'h77};
    for (int i = 0; i < 17; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of WAIT: the re-presented request must wait the full LIMIT+1 cycles again.
    v = '{0, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 0, 0, 5'd7, 32'h77};
    apply(v, "rw0");
    v.e_we = 1; v.e_rd = 5'd1; v.e_wd = 32'h1;
    apply(v, "rw1");
    v.rst = 1;
    apply(v, "rw_rst");
    v.rst = 0; v.e_we = 0; v.e_rd = 5'd0; v.e_wd = 32'h0;
    apply(v, "rw3");
    v.e_we = 1; v.e_rd = 5'd1; v.e_wd = 32'h1;
    for (int i = 0; i < LIMIT; i++) apply(v, $sformatf("rw_blk%0d", i));
    v.e_ready = 1; v.e_stall = 1;
    apply(v, "rw_force");
    v = '{0, 1, 5'd1, 32'h1, 0, 5'd0, 32'h0, 0, 0, 1, 5'd2, 32'h2};
    apply(v, "rw_after");
    v = '{0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 1, 5'd1, 32'h1};
    apply(v, "rw_idle");

    @(negedge clk);
    reset = 1'b1; wb_valid = 0; ext_valid = 0;
    @(negedge clk);
    m_blk = 0; m_we = 0; m_rd = 0; m_wd = 0;
    ex_pend = 0; p_rd = 0; p_d = 0;

    for (int c = 0; c < 400; c++) begin
      logic forced;
      v.rst  = ($urandom_range(0, 49) == 0);
      v.wbv  = ($urandom_range(0, 9) < 6);
      v.wbrd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      v.wbd  = $urandom;
      if (!ex_pend && $urandom_range(0, 2) == 0) begin
        ex_pend = 1;
        p_rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        p_d  = $urandom;
      end
      v.exv = ex_pend; v.exrd = p_rd; v.exd = p_d;
      forced      = (m_blk == LIMIT + 1);
      v.e_ready   = !v.rst && ex_pend && (forced || !v.wbv);
      v.e_stall   = forced;
      v.e_we      = m_we; v.e_rd = m_rd; v.e_wd = m_wd;
      apply(v, "rand");
      if (v.rst) begin
        m_blk = 0; m_we = 0; m_rd = 0; m_wd = 0;
      end else begin
        if (v.e_ready) begin
          m_we = (p_rd != 0); m_rd = p_rd; m_wd = p_d;
        end else if (!forced && v.wbv) begin
          m_we = (v.wbrd != 0); m_rd = v.wbrd; m_wd = v.wbd;
        end else begin
          m_we = 0;
        end
        if (forced || v.e_ready || !ex_pend) m_blk = 0;
        else m_blk++;
      end
      if (v.e_ready) ex_pend = 0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
